// File: rtl/line_burst_bridge_pkg.sv
// Shared types and sizing helpers for the cache-line to beat-burst bridge.
package line_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CMD     = 3'd1,
        WDATA   = 3'd2,
        RDATA   = 3'd3,
        RESP    = 3'd4,
        RELEASE = 3'd5
    } state_t;

    // Number of external beats that make up one cache line.
    function automatic int calc_beats(input int line_w, input int beat_w);
        return line_w / beat_w;
    endfunction

    // Number of byte-offset bits inside one line (forced to zero on the bus).
    function automatic int calc_offs(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    // Beat counter width; at least one bit even for a single-beat line.
    function automatic int calc_cnt_w(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

    localparam int DEF_BEATS = calc_beats(512, 64);
    localparam int DEF_OFFS  = calc_offs(512);
    localparam int DEF_CNT_W = calc_cnt_w(DEF_BEATS);

endpackage

// File: rtl/line_burst_bridge_if.sv
// External command / write-beat / read-beat bus between the bridge and memory.
interface line_burst_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int BEAT_WIDTH = 64
);
    logic                  ext_cmd_valid;
    logic                  ext_cmd_ready;
    logic [ADDR_WIDTH-1:0] ext_cmd_addr;
    logic                  ext_cmd_we;
    logic [BEAT_WIDTH-1:0] ext_wdata;
    logic                  ext_wvalid;
    logic                  ext_wready;
    logic                  ext_wlast;
    logic [BEAT_WIDTH-1:0] ext_rdata;
    logic                  ext_rvalid;
    logic                  ext_rlast;
    logic                  ext_rready;

    // Bridge side: issues commands and write beats, accepts read beats.
    modport master (
        output ext_cmd_valid, ext_cmd_addr, ext_cmd_we,
        output ext_wdata, ext_wvalid, ext_wlast,
        output ext_rready,
        input  ext_cmd_ready, ext_wready,
        input  ext_rdata, ext_rvalid, ext_rlast
    );

    // Memory side.
    modport slave (
        input  ext_cmd_valid, ext_cmd_addr, ext_cmd_we,
        input  ext_wdata, ext_wvalid, ext_wlast,
        input  ext_rready,
        output ext_cmd_ready, ext_wready,
        output ext_rdata, ext_rvalid, ext_rlast
    );
endinterface

// File: rtl/line_burst_bridge_serdes.sv
// Line register pair: write line sliced into beats by the shared counter, and
// a read assembly buffer filled one beat slot at a time.
module line_beat_serdes #(
    parameter int LINE_W = 512,
    parameter int BEAT_W = 64,
    parameter int CNT_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [LINE_W-1:0] i_load_line,
    input  logic [CNT_W-1:0]  i_cnt,
    input  logic              i_beat_we,
    input  logic [BEAT_W-1:0] i_beat,
    output logic [BEAT_W-1:0] o_wbeat,
    output logic [LINE_W-1:0] o_rline_nxt
);
    logic [LINE_W-1:0] r_wline;
    logic [LINE_W-1:0] r_rbuf;
    logic [LINE_W-1:0] w_rline_nxt;

    // Next assembly-buffer value: drop the incoming beat into its slot, keep the rest.
    always_comb begin
        w_rline_nxt = r_rbuf;
        if (i_beat_we) begin
            w_rline_nxt[int'(i_cnt)*BEAT_W +: BEAT_W] = i_beat;
        end
    end

    // Hold the captured write line and the read assembly buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wline <= '0;
            r_rbuf  <= '0;
        end else begin
            if (i_load) begin
                r_wline <= i_load_line;
            end
            r_rbuf <= w_rline_nxt;
        end
    end

    assign o_wbeat     = r_wline[int'(i_cnt)*BEAT_W +: BEAT_W];
    assign o_rline_nxt = w_rline_nxt;

endmodule

// File: rtl/line_burst_bridge.sv
// Converts single req/ack cache-line transfers into a command plus a beat burst
// on the external valid/ready bus, with one ack (and error flag) per line.
module line_burst_bridge
    import line_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH       = 32,
    parameter int CACHE_LINE_WIDTH = 512,
    parameter int BEAT_WIDTH       = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ADDR_WIDTH-1:0]       line_addr,
    input  logic [CACHE_LINE_WIDTH-1:0] line_wdata,
    output logic [CACHE_LINE_WIDTH-1:0] line_rdata,
    input  logic                        line_req,
    input  logic                        line_we,
    output logic                        line_ack,
    output logic                        line_err,
    line_burst_bridge_if.master         ext,
    output logic                        busy
);
    localparam int BEATS = calc_beats(CACHE_LINE_WIDTH, BEAT_WIDTH);
    localparam int OFFS  = calc_offs(CACHE_LINE_WIDTH);
    localparam int CNT_W = calc_cnt_w(BEATS);
    localparam logic [CNT_W-1:0]      LAST_CNT   = CNT_W'(BEATS - 1);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {ADDR_WIDTH{1'b1}} << OFFS;

    state_t                      r_state;
    state_t                      w_state_nxt;
    logic [CNT_W-1:0]            r_cnt;
    logic [CNT_W-1:0]            w_cnt_nxt;
    logic                        r_err;
    logic                        w_err_nxt;
    logic [ADDR_WIDTH-1:0]       r_addr;
    logic                        r_we;
    logic [CACHE_LINE_WIDTH-1:0] r_rdata;
    logic                        w_capture;
    logic                        w_beat_wr;
    logic                        w_rd_done;
    logic [BEAT_WIDTH-1:0]       w_wbeat;
    logic [CACHE_LINE_WIDTH-1:0] w_rline_nxt;

    line_beat_serdes #(
        .LINE_W (CACHE_LINE_WIDTH),
        .BEAT_W (BEAT_WIDTH),
        .CNT_W  (CNT_W)
    ) u_serdes (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_load      (w_capture),
        .i_load_line (line_wdata),
        .i_cnt       (r_cnt),
        .i_beat_we   (w_beat_wr),
        .i_beat      (ext.ext_rdata),
        .o_wbeat     (w_wbeat),
        .o_rline_nxt (w_rline_nxt)
    );

    // Next-state, counter and error decode for the transfer sequence.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_capture   = 1'b0;
        w_beat_wr   = 1'b0;
        w_rd_done   = 1'b0;
        case (r_state)
            IDLE: begin
                if (line_req) begin
                    w_capture   = 1'b1;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = CMD;
                end
            end
            CMD: begin
                if (ext.ext_cmd_ready) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = r_we ? WDATA : RDATA;
                end
            end
            WDATA: begin
                if (ext.ext_wready) begin
                    if (r_cnt == LAST_CNT) begin
                        w_err_nxt   = 1'b0;
                        w_state_nxt = RESP;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            RDATA: begin
                if (ext.ext_rvalid) begin
                    w_beat_wr = 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        // Full burst: only well-formed if it is marked last.
                        w_err_nxt   = ~ext.ext_rlast;
                        w_rd_done   = 1'b1;
                        w_state_nxt = RESP;
                    end else if (ext.ext_rlast) begin
                        // Early termination: remaining slots keep old data.
                        w_err_nxt   = 1'b1;
                        w_rd_done   = 1'b1;
                        w_state_nxt = RESP;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            RESP: begin
                w_cnt_nxt   = '0;
                w_state_nxt = RELEASE;
            end
            RELEASE: begin
                // A level req still high after ack must not start a new line.
                if (!line_req) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Captured command, beat counter, error flag and the presented read line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_we    <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_cnt <= w_cnt_nxt;
            r_err <= w_err_nxt;
            if (w_capture) begin
                r_addr <= line_addr & ALIGN_MASK;
                r_we   <= line_we;
            end
            if (w_rd_done) begin
                r_rdata <= w_rline_nxt;
            end
        end
    end

    assign ext.ext_cmd_valid = (r_state == CMD);
    assign ext.ext_cmd_addr  = r_addr;
    assign ext.ext_cmd_we    = r_we;
    assign ext.ext_wvalid    = (r_state == WDATA);
    assign ext.ext_wlast     = (r_state == WDATA) && (r_cnt == LAST_CNT);
    assign ext.ext_wdata     = (r_state == WDATA) ? w_wbeat : '0;
    assign ext.ext_rready    = (r_state == RDATA);
    assign line_ack          = (r_state == RESP);
    assign line_err          = (r_state == RESP) && r_err;
    assign line_rdata        = r_rdata;
    assign busy              = (r_state != IDLE);

endmodule

// File: tb/tb_line_burst_bridge.sv
// Directed scoreboard bench for line_burst_bridge.
module tb_line_burst_bridge;
    import line_bridge_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [31:0]  line_addr = '0;
    logic [511:0] line_wdata = '0;
    logic [511:0] line_rdata;
    logic         line_req = 1'b0;
    logic         line_we = 1'b0;
    logic         line_ack;
    logic         line_err;
    logic         busy;

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    typedef struct { logic [31:0] addr; logic we; } cmd_t;
    typedef struct { logic [63:0] d; logic last; } wb_t;
    typedef struct { logic err; logic [511:0] rd; int cyc; } resp_t;

    cmd_t  q_cmd[$];
    wb_t   q_w[$];
    resp_t q_r[$];
    cmd_t  m_c;
    wb_t   m_w;
    resp_t m_r;

    line_burst_bridge_if #(.ADDR_WIDTH(32), .BEAT_WIDTH(64)) ext_if ();

    line_burst_bridge #(
        .ADDR_WIDTH       (32),
        .CACHE_LINE_WIDTH (512),
        .BEAT_WIDTH       (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_addr  (line_addr),
        .line_wdata (line_wdata),
        .line_rdata (line_rdata),
        .line_req   (line_req),
        .line_we    (line_we),
        .line_ack   (line_ack),
        .line_err   (line_err),
        .ext        (ext_if),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    endtask

    // Monitor: compare every handshake / ack against the queued expectations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ext_if.ext_cmd_valid && ext_if.ext_cmd_ready) begin
                if (q_cmd.size() == 0) chk("cmd_unexpected", 512'(1), 512'(0));
                else begin
                    m_c = q_cmd.pop_front();
                    chk("cmd_addr", 512'(ext_if.ext_cmd_addr), 512'(m_c.addr));
                    chk("cmd_we", 512'(ext_if.ext_cmd_we), 512'(m_c.we));
                end
            end
            if (ext_if.ext_wvalid && ext_if.ext_wready) begin
                if (q_w.size() == 0) chk("wbeat_unexpected", 512'(1), 512'(0));
                else begin
                    m_w = q_w.pop_front();
                    chk("wbeat_data", 512'(ext_if.ext_wdata), 512'(m_w.d));
                    chk("wbeat_last", 512'(ext_if.ext_wlast), 512'(m_w.last));
                end
            end
            if (line_ack) begin
                if (q_r.size() == 0) chk("ack_unexpected", 512'(1), 512'(0));
                else begin
                    m_r = q_r.pop_front();
                    chk("ack_err", 512'(line_err), 512'(m_r.err));
                    chk("ack_rdata", line_rdata, m_r.rd);
                    chk("ack_cycle", 512'(cyc), 512'(m_r.cyc));
                end
            end
        end
    end

    // One line transfer with a reactive memory model; expectations are queued first.
    task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] exp_addr,
                           input logic [511:0] data, input int nbeats, input int rlast_idx,
                           input int cmd_stall, input bit wtoggle, input int hold,
                           input logic exp_err, input logic [511:0] exp_rdata, input int exp_lat);
        int k;
        int idx;
        bit hs;
        bit got;
        cmd_t c;
        wb_t w;
        resp_t r;
        @(posedge clk); #1;
        c.addr = exp_addr; c.we = we;
        q_cmd.push_back(c);
        if (we) begin
            for (int i = 0; i < 8; i++) begin
                w.d = data[i*64 +: 64];
                w.last = (i == 7);
                q_w.push_back(w);
            end
        end
        r.err = exp_err; r.rd = exp_rdata; r.cyc = cyc + exp_lat;
        q_r.push_back(r);
        line_req = 1'b1; line_we = we; line_addr = addr;
        line_wdata = we ? data : ~data;
        k = 0; idx = 0; got = 1'b0;
        while (!got && k < 300) begin
            ext_if.ext_cmd_ready = (k >= 1 + cmd_stall);
            ext_if.ext_wready    = wtoggle ? (k % 2 == 0) : 1'b1;
            ext_if.ext_rvalid    = !we && (idx < nbeats);
            ext_if.ext_rdata     = (idx < 8) ? data[idx*64 +: 64] : 64'h0;
            ext_if.ext_rlast     = (idx == rlast_idx);
            @(negedge clk);
            hs = ext_if.ext_rvalid && ext_if.ext_rready;
            if (ext_if.ext_cmd_valid && !ext_if.ext_cmd_ready) begin
                chk("cmd_stall_addr", 512'(ext_if.ext_cmd_addr), 512'(exp_addr));
                chk("cmd_stall_we", 512'(ext_if.ext_cmd_we), 512'(we));
            end
            if (line_ack) got = 1'b1;
            @(posedge clk); #1;
            k++;
            if (hs) idx++;
            if (k == 1) begin
                // Inputs after capture must be ignored.
                line_addr = ~addr; line_we = ~we; line_wdata = ~line_wdata;
            end
        end
        if (!got) chk("ack_timeout", 512'(0), 512'(1));
        ext_if.ext_rvalid = 1'b0; ext_if.ext_rlast = 1'b0;
        ext_if.ext_cmd_ready = 1'b1; ext_if.ext_wready = 1'b1;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_no_cmd", 512'(ext_if.ext_cmd_valid), 512'(0));
            chk("hold_busy", 512'(busy), 512'(1));
            @(posedge clk); #1;
        end
        line_req = 1'b0;
    endtask

    logic [511:0] L1, W2, B3, E3, C3, D3, E4, F4, G5, H6, J7;

    initial begin
        ext_if.ext_cmd_ready = 1'b1;
        ext_if.ext_wready    = 1'b1;
        ext_if.ext_rvalid    = 1'b0;
        ext_if.ext_rlast     = 1'b0;
        ext_if.ext_rdata     = '0;
        for (int k = 0; k < 8; k++) begin
            L1[k*64 +: 64] = 64'h11 * (k + 1);
            W2[k*64 +: 64] = 64'hA0 + k;
            B3[k*64 +: 64] = (k < 5) ? 64'hB0 + k : 64'h0;
            C3[k*64 +: 64] = {32'hC0DE_0000 + k, 32'h1234_5670 + k};
            D3[k*64 +: 64] = {32'hD00D_F000 + k, 32'hFFFF_0000 - k};
            E4[k*64 +: 64] = {32'hE000_0000 + k, 32'h0BAD_CAFE};
            F4[k*64 +: 64] = {32'hF00F_0000 + k, 32'h5555_AAAA};
            G5[k*64 +: 64] = {32'h6666_0000 + k, 32'h9999_0000 + k};
            H6[k*64 +: 64] = {32'h7777_7700 + k, 32'h1357_9BDF};
            J7[k*64 +: 64] = {32'h8ACE_0000 + k, 32'hFEDC_BA90 + k};
        end
        E3 = {L1[511:320], 64'hB4, 64'hB3, 64'hB2, 64'hB1, 64'hB0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 512'({line_ack, line_err, busy, ext_if.ext_cmd_valid, ext_if.ext_cmd_we,
                              ext_if.ext_wvalid, ext_if.ext_wlast, ext_if.ext_rready}), 512'(0));
        chk("rst_cmd_addr", 512'(ext_if.ext_cmd_addr), 512'(0));
        chk("rst_rdata", line_rdata, 512'(0));
        @(negedge clk); rst_n = 1'b1;

        // Full-speed read, unaligned address
        run_txn(1'b0, 32'h0000_1234, 32'h0000_1200, L1, 8, 7, 0, 1'b0, 0, 1'b0, L1, 10);
        // Write with wready toggling; read line must be untouched
        run_txn(1'b1, 32'h0000_5A00, 32'h0000_5A00, W2, 8, 8, 0, 1'b1, 0, 1'b0, L1, 17);
        // Early rlast on beat 4
        run_txn(1'b0, 32'h0000_207F, 32'h0000_2040, B3, 5, 4, 0, 1'b0, 0, 1'b1, E3, 7);
        // Well-formed read clears the error
        run_txn(1'b0, 32'h0000_3000, 32'h0000_3000, C3, 8, 7, 0, 1'b0, 0, 1'b0, C3, 10);
        // Full burst with no rlast marker
        run_txn(1'b0, 32'h0000_3041, 32'h0000_3040, D3, 8, 8, 0, 1'b0, 0, 1'b1, D3, 10);
        // Req held 5 cycles after ack, then exactly one further transaction
        run_txn(1'b0, 32'h0000_0040, 32'h0000_0040, E4, 8, 7, 0, 1'b0, 5, 1'b0, E4, 10);
        run_txn(1'b1, 32'h0001_00FF, 32'h0001_00C0, F4, 8, 8, 0, 1'b0, 0, 1'b0, E4, 10);
        // Command stalled 7 cycles
        run_txn(1'b0, 32'hFFFF_FFC5, 32'hFFFF_FFC0, G5, 8, 7, 7, 1'b0, 0, 1'b0, G5, 17);

        // Reset during write beat 3
        @(posedge clk); #1;
        m_c.addr = 32'h0000_9000; m_c.we = 1'b1;
        q_cmd.push_back(m_c);
        for (int i = 0; i < 3; i++) begin
            m_w.d = H6[i*64 +: 64]; m_w.last = 1'b0;
            q_w.push_back(m_w);
        end
        line_req = 1'b1; line_we = 1'b1; line_addr = 32'h0000_9000; line_wdata = H6;
        repeat (5) @(posedge clk);
        #1;
        ext_if.ext_wready = 1'b0;
        @(negedge clk);
        chk("rst_pre_wvalid", 512'(ext_if.ext_wvalid), 512'(1));
        chk("rst_pre_wdata", 512'(ext_if.ext_wdata), 512'(H6[3*64 +: 64]));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_ctrl", 512'({line_ack, line_err, busy, ext_if.ext_cmd_valid, ext_if.ext_cmd_we,
                               ext_if.ext_wvalid, ext_if.ext_wlast, ext_if.ext_rready}), 512'(0));
        chk("arst_wdata", 512'(ext_if.ext_wdata), 512'(0));
        chk("arst_cmd_addr", 512'(ext_if.ext_cmd_addr), 512'(0));
        chk("arst_rdata", line_rdata, 512'(0));
        line_req = 1'b0; ext_if.ext_wready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        chk("arst_wbeats_done", 512'(q_w.size()), 512'(0));
        @(negedge clk);
        chk("arst_idle", 512'(busy), 512'(0));

        // Normal read after reset
        run_txn(1'b0, 32'h0000_ABCD, 32'h0000_ABC0, J7, 8, 7, 0, 1'b0, 0, 1'b0, J7, 10);

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("end_cmd_q", 512'(q_cmd.size()), 512'(0));
        chk("end_w_q", 512'(q_w.size()), 512'(0));
        chk("end_resp_q", 512'(q_r.size()), 512'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
